// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: control-bit positions, FSM states
// and the MEM/WB payload record.
package mem_pkg;

  localparam int unsigned MEM_READ_BIT      = 1;
  localparam int unsigned MEM_WRITE_BIT     = 0;
  localparam int unsigned WB_MEM_TO_REG_BIT = 1;
  localparam int unsigned WB_REG_WRITE_BIT  = 0;
  localparam int unsigned REG_IDX_W         = 5;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [1:0]           ctrl_wb;
    logic [31:0]          read_data;
    logic [31:0]          alu_result;
    logic [REG_IDX_W-1:0] write_reg;
    logic                 error;
  } memwb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads when enabled, a bubble load clears the
// whole slot, and reset clears it synchronously.
module mem_wb_reg
  import mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_en,
  input  logic   bubble,
  input  memwb_t d,
  output memwb_t q
);

  memwb_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (load_en) begin
      slot_d = bubble ? memwb_t'('0) : d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q = slot_q;

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage with a req/ready data-memory port, access timeout and
// misalignment detection, feeding the MEM/WB register.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic [1:0]           ex_control_mem,
  input  logic [1:0]           ex_control_wb,
  input  logic [31:0]          ex_alu_result,
  input  logic [31:0]          ex_write_data,
  input  logic [REG_IDX_W-1:0] ex_write_reg,
  output logic                 mem_stall,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [31:0]          dmem_addr,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_ready,
  output logic                 mem_valid,
  output logic [1:0]           mem_control_wb,
  output logic [31:0]          mem_read_data,
  output logic [31:0]          mem_alu_result,
  output logic [REG_IDX_W-1:0] mem_write_reg,
  output logic                 mem_error
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic                 is_read_q, is_read_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [1:0]           ctrl_wb_q, ctrl_wb_d;
  logic [REG_IDX_W-1:0] wreg_q, wreg_d;

  logic   is_read, is_write, is_mem, misaligned, stall;
  logic   wb_load, wb_bubble;
  memwb_t wb_d, wb_q;

  always_comb begin
    is_read    = ex_control_mem[MEM_READ_BIT];
    is_write   = ex_control_mem[MEM_WRITE_BIT];
    is_mem     = ex_valid & (is_read | is_write);
    misaligned = is_mem & (ex_alu_result[1:0] != 2'b00);

    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ctrl_wb_d = ctrl_wb_q;
    wreg_d    = wreg_q;
    stall     = 1'b0;
    wb_load   = 1'b0;
    wb_bubble = 1'b0;
    wb_d      = '0;

    unique case (state_q)
      IDLE: begin
        wb_load = 1'b1;
        if (is_mem && !misaligned) begin
          // Both control bits set is a read, so we only when write-only.
          stall     = 1'b1;
          wb_bubble = 1'b1;
          state_d   = ACCESS;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = is_write & ~is_read;
          is_read_d = is_read;
          addr_d    = ex_alu_result;
          wdata_d   = ex_write_data;
          ctrl_wb_d = ex_control_wb;
          wreg_d    = ex_write_reg;
        end else begin
          wb_d.valid      = ex_valid;
          wb_d.ctrl_wb    = ex_control_wb;
          wb_d.alu_result = ex_alu_result;
          wb_d.write_reg  = ex_write_reg;
          wb_d.error      = misaligned;
          if (misaligned) begin
            wb_d.ctrl_wb[WB_REG_WRITE_BIT] = 1'b0;
          end
        end
      end

      ACCESS: begin
        wb_d.valid      = 1'b1;
        wb_d.ctrl_wb    = ctrl_wb_q;
        wb_d.alu_result = addr_q;
        wb_d.write_reg  = wreg_q;
        if (dmem_ready) begin
          wb_load        = 1'b1;
          wb_d.read_data = is_read_q ? dmem_rdata : '0;
          req_d          = 1'b0;
          state_d        = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          // Abort: the held instruction retires with its register write killed.
          wb_load                        = 1'b1;
          wb_d.ctrl_wb[WB_REG_WRITE_BIT] = 1'b0;
          wb_d.error                     = 1'b1;
          req_d                          = 1'b0;
          state_d                        = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ctrl_wb_q <= '0;
      wreg_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ctrl_wb_q <= ctrl_wb_d;
      wreg_q    <= wreg_d;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (wb_load),
    .bubble  (wb_bubble),
    .d       (wb_d),
    .q       (wb_q)
  );

  assign mem_stall      = stall & rst_n;
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign mem_valid      = wb_q.valid;
  assign mem_control_wb = wb_q.ctrl_wb;
  assign mem_read_data  = wb_q.read_data;
  assign mem_alu_result = wb_q.alu_result;
  assign mem_write_reg  = wb_q.write_reg;
  assign mem_error      = wb_q.error;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: single-cycle vector table plus
// hand-written load/store/timeout/reset sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [1:0]  ex_control_mem;
  logic [1:0]  ex_control_wb;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_write_data;
  logic [4:0]  ex_write_reg;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_valid;
  logic [1:0]  mem_control_wb;
  logic [31:0] mem_read_data;
  logic [31:0] mem_alu_result;
  logic [4:0]  mem_write_reg;
  logic        mem_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_control_mem (ex_control_mem),
    .ex_control_wb  (ex_control_wb),
    .ex_alu_result  (ex_alu_result),
    .ex_write_data  (ex_write_data),
    .ex_write_reg   (ex_write_reg),
    .mem_stall      (mem_stall),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ready     (dmem_ready),
    .mem_valid      (mem_valid),
    .mem_control_wb (mem_control_wb),
    .mem_read_data  (mem_read_data),
    .mem_alu_result (mem_alu_result),
    .mem_write_reg  (mem_write_reg),
    .mem_error      (mem_error)
  );

  typedef struct {
    logic        v;
    logic [1:0]  cm;
    logic [1:0]  cwb;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        ev;
    logic [1:0]  ewb;
    logic        eerr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] cm, input logic [1:0] cwb,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    ex_valid       = v;
    ex_control_mem = cm;
    ex_control_wb  = cwb;
    ex_alu_result  = alu;
    ex_write_data  = wd;
    ex_write_reg   = wr;
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic [1:0] wb,
                        input logic [31:0] rd, input logic [31:0] alu,
                        input logic [4:0] wr, input logic err);
    chk({tag, "_valid"}, 32'(mem_valid), 32'(v));
    chk({tag, "_wb"},    32'(mem_control_wb), 32'(wb));
    chk({tag, "_rdata"}, mem_read_data, rd);
    chk({tag, "_alu"},   mem_alu_result, alu);
    chk({tag, "_wreg"},  32'(mem_write_reg), 32'(wr));
    chk({tag, "_err"},   32'(mem_error), 32'(err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           v     cm     cwb    alu            wr     ev    ewb    eerr
    vecs[0] = '{1'b1, 2'b00, 2'b01, 32'h0000_0010, 5'd3,  1'b1, 2'b01, 1'b0};
    vecs[1] = '{1'b1, 2'b10, 2'b11, 32'h0000_0102, 5'd4,  1'b1, 2'b10, 1'b1};
    vecs[2] = '{1'b0, 2'b00, 2'b11, 32'h0000_0044, 5'd5,  1'b0, 2'b00, 1'b0};
    vecs[3] = '{1'b1, 2'b01, 2'b00, 32'h0000_0201, 5'd6,  1'b1, 2'b00, 1'b1};
    vecs[4] = '{1'b1, 2'b00, 2'b11, 32'hFFFF_FFFC, 5'd31, 1'b1, 2'b11, 1'b0};
    vecs[5] = '{1'b1, 2'b11, 2'b01, 32'h0000_0003, 5'd8,  1'b1, 2'b00, 1'b1};
    vecs[6] = '{1'b0, 2'b10, 2'b01, 32'h0000_0101, 5'd9,  1'b0, 2'b00, 1'b0};

    // Reset with an aligned load presented: no stall while in reset.
    rst_n      = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    drive(1'b1, 2'b10, 2'b11, 32'h0000_0100, 32'h0, 5'd1);
    #1;
    chk("rst_stall", 32'(mem_stall), 32'h0);
    tick();
    tick();
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_we", 32'(dmem_we), 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk_wb("rst", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b1;
    tick();

    // Single-cycle instructions: ALU ops, bubbles, misaligned accesses.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].v, vecs[i].cm, vecs[i].cwb, vecs[i].alu, 32'hA5A5_A5A5, vecs[i].wr);
      #1;
      chk("tbl_stall", 32'(mem_stall), 32'h0);
      tick();
      chk("tbl_req", 32'(dmem_req), 32'h0);
      chk("tbl_valid", 32'(mem_valid), 32'(vecs[i].ev));
      chk("tbl_rdata", mem_read_data, 32'h0);
      chk("tbl_err", 32'(mem_error), 32'(vecs[i].eerr));
      if (vecs[i].ev) begin
        chk("tbl_wb", 32'(mem_control_wb), 32'(vecs[i].ewb));
        chk("tbl_alu", mem_alu_result, vecs[i].alu);
        chk("tbl_wreg", 32'(mem_write_reg), 32'(vecs[i].wr));
      end
    end

    // Load from 0x100, ready on the 3rd ACCESS cycle.
    drive(1'b1, 2'b10, 2'b11, 32'h0000_0100, 32'h0, 5'd7);
    #1;
    chk("ld_stall0", 32'(mem_stall), 32'h1);
    chk("ld_req0", 32'(dmem_req), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) begin
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
      end
      #1;
      chk("ld_req", 32'(dmem_req), 32'h1);
      chk("ld_we", 32'(dmem_we), 32'h0);
      chk("ld_addr", dmem_addr, 32'h0000_0100);
      chk("ld_bubble", 32'(mem_valid), 32'h0);
      chk("ld_stall", 32'(mem_stall), (k < 3) ? 32'h1 : 32'h0);
    end
    tick();
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("ld_req_done", 32'(dmem_req), 32'h0);
    chk_wb("ld", 1'b1, 2'b11, 32'hDEAD_BEEF, 32'h0000_0100, 5'd7, 1'b0);

    // Store 0x12345678 to 0x200, ready on the 1st ACCESS cycle.
    drive(1'b1, 2'b01, 2'b00, 32'h0000_0200, 32'h1234_5678, 5'd2);
    #1;
    chk("st_stall0", 32'(mem_stall), 32'h1);
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    #1;
    chk("st_req", 32'(dmem_req), 32'h1);
    chk("st_we", 32'(dmem_we), 32'h1);
    chk("st_addr", dmem_addr, 32'h0000_0200);
    chk("st_wdata", dmem_wdata, 32'h1234_5678);
    chk("st_stall1", 32'(mem_stall), 32'h0);
    tick();
    dmem_ready = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    chk("st_req_done", 32'(dmem_req), 32'h0);
    chk_wb("st", 1'b1, 2'b00, 32'h0, 32'h0000_0200, 5'd2, 1'b0);

    // Timeout: ready never arrives, req high for exactly 4 cycles.
    drive(1'b1, 2'b10, 2'b11, 32'h0000_0300, 32'h0, 5'd10);
    #1;
    chk("to_stall0", 32'(mem_stall), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("to_req", 32'(dmem_req), 32'h1);
      chk("to_stall", 32'(mem_stall), (k < 4) ? 32'h1 : 32'h0);
      chk("to_err_early", 32'(mem_error), 32'h0);
    end
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    chk("to_req_done", 32'(dmem_req), 32'h0);
    chk_wb("to", 1'b1, 2'b10, 32'h0, 32'h0000_0300, 5'd10, 1'b0 | 1'b1);
    drive(1'b1, 2'b00, 2'b01, 32'h0000_0050, 32'h0, 5'd11);
    #1;
    chk("to_idle_stall", 32'(mem_stall), 32'h0);
    tick();
    chk_wb("to_after", 1'b1, 2'b01, 32'h0, 32'h0000_0050, 5'd11, 1'b0);

    // Ready in the would-be timeout cycle is a success.
    drive(1'b1, 2'b10, 2'b11, 32'h0000_0400, 32'h0, 5'd12);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) begin
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
      end
    end
    tick();
    dmem_ready = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    chk_wb("late", 1'b1, 2'b11, 32'hCAFE_F00D, 32'h0000_0400, 5'd12, 1'b0);

    // Reset in the middle of an access.
    drive(1'b1, 2'b01, 2'b00, 32'h0000_0500, 32'h0BAD_F00D, 5'd13);
    tick();
    chk("rr_req_pre", 32'(dmem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rr_stall", 32'(mem_stall), 32'h0);
    tick();
    chk("rr_req", 32'(dmem_req), 32'h0);
    chk("rr_we", 32'(dmem_we), 32'h0);
    chk("rr_addr", dmem_addr, 32'h0);
    chk("rr_wdata", dmem_wdata, 32'h0);
    chk_wb("rr", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 2'b00, 2'b01, 32'h0000_0020, 32'h0, 5'd14);
    #1;
    chk("rr_alu_stall", 32'(mem_stall), 32'h0);
    tick();
    chk_wb("rr_alu", 1'b1, 2'b01, 32'h0, 32'h0000_0020, 5'd14, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
